phase_driver_gen: RTL
=====================

// Module: phase_driver_gen
// PURPOSE
//  Generates the four non-overlapping phase drive lines (FAZ1DR..FAZ4DR, FAZ2DR_n) consumed by the phase buffer circuits.
//  Each phase slot is DIV clocks of drive followed by GAP clocks of dead time.
//  Runs free while run is high. A step pulse issues exactly one 4-phase cycle.
//  Sits upstream of the phase buffers in the CDU timing chain.
// PARAMETERS
//  DIV    4   clocks per phase drive window (>=1)
//  GAP    1   dead clocks after each drive window, all lines inactive (>=0)
//  CNT_W  16  width of cycle_count
// PORTS
//  clk          in   1      single system clock, all logic on rising edge
//  rst          in   1      asynchronous, active-high reset
//  run          in   1      level: cycle continuously while high
//  step         in   1      1-clk pulse: run one cycle when idle
//  FAZ1DR       out  1      phase 1 drive, active-low
//  FAZ2DR       out  1      phase 2 drive, active-low
//  FAZ2DR_n     out  1      complement of FAZ2DR, active-high
//  FAZ3DR       out  1      phase 3 drive, active-low
//  FAZ4DR       out  1      phase 4 drive, active-low
//  phase        out  2      index of current/last phase, 0..3 = FAZ1..FAZ4
//  busy         out  1      high whenever not IDLE
//  cycle_done   out  1      1-clk pulse on the final clock of a 4-phase cycle
//  cycle_count  out  CNT_W  completed cycles since reset; wraps to 0
// BEHAVIOUR
//  - All outputs are registered; no combinational path from inputs to outputs.
//  - Reset values (async):
//    - state=IDLE, slot counter=0, phase=0, busy=0, cycle_done=0, cycle_count=0
//    - FAZ1DR=FAZ2DR=FAZ3DR=FAZ4DR=1 (inactive), FAZ2DR_n=0
//  - States: IDLE, DRIVE, DEAD.
//  - IDLE:
//    - If run=1 or step=1 is sampled at edge k, then at edge k+1: DRIVE, phase=0, FAZ1DR=0, busy=1.
//    - Otherwise stay in IDLE.
//  - DRIVE:
//    - The phase-selected line is low for exactly DIV clocks. All other lines are inactive.
//    - After DIV clocks: go to DEAD if GAP>0.
//    - If GAP=0, behave as if DEAD had just completed (see DEAD).
//  - DEAD:
//    - All drive lines are inactive (FAZ2DR_n=0) for GAP clocks.
//    - If phase<3: phase+1, enter DRIVE.
//    - If phase==3: the cycle ends. run sampled on the final clock decides what follows:
//      - run=1: phase=0, DRIVE, with no idle gap.
//      - run=0: go to IDLE, busy=0 on the next edge.
//  - cycle_done asserts for 1 clock, coincident with the final clock of phase 3.
//    - That is the last DEAD clock, or the last DRIVE clock if GAP=0.
//    - cycle_count increments on the same edge that clears cycle_done.
//  - Cycle period is 4*(DIV+GAP) clocks. At most one drive line is ever low at a time.
//  - FAZ2DR_n always equals ~FAZ2DR, updated in the same register stage.
//  - run falling mid-cycle: the current cycle completes through phase 3, then the block goes IDLE. No truncation.
//  - step while busy: ignored, not queued. step and run together in IDLE: a single start.
//  - step held high for multiple clocks in IDLE: one cycle per IDLE entry.
//  - rst mid-cycle: all lines go inactive immediately (async). Restart requires run or step after rst is released.
//  - cycle_count wraps from 2^CNT_W-1 to 0 with no flag.
// TESTING
//  1. rst pulse mid-DRIVE of phase 2 -> FAZ2DR=1, FAZ2DR_n=0, busy=0 with no clock edge; cycle_count=0.
//  2. DIV=4 GAP=1, step pulse at edge 0:
//     - FAZ1DR low on edges 1-4, FAZ2DR low on 6-9, FAZ3DR low on 11-14, FAZ4DR low on 16-19.
//     - cycle_done high at 20, busy=0 at 21, cycle_count=1.
//  3. run held high for 3 cycles (DIV=4 GAP=1) -> period 20 clocks, three cycle_done pulses, cycle_count=3.
//     Then drop run during phase 1 -> the cycle finishes, cycle_count=4, IDLE.
//  4. GAP=0, DIV=1, run high -> FAZ1..FAZ4 each low 1 clock, back-to-back, period 4, never two lines low at once.
//  5. step asserted while busy in phase 2 -> no extra cycle after completion; cycle_count advances by 1 only.
//  6. CNT_W=2, run for 5 cycles -> cycle_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/phase_driver_gen.sv
// Four-phase non-overlapping drive generator: each phase slot is DIV clocks of
// active-low drive followed by GAP dead clocks; free-running on run, single cycle on step.
module phase_driver_gen #(
    parameter int DIV   = 4,
    parameter int GAP   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    output logic             FAZ1DR,
    output logic             FAZ2DR,
    output logic             FAZ2DR_n,
    output logic             FAZ3DR,
    output logic             FAZ4DR,
    output logic [1:0]       phase,
    output logic             busy,
    output logic             cycle_done,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int SPAN = (DIV > GAP) ? DIV : GAP;
    localparam int SW   = (SPAN > 1) ? $clog2(SPAN) : 1;
    localparam logic [SW-1:0] DRV_LAST = SW'(DIV - 1);
    localparam logic [SW-1:0] GAP_LAST = SW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {IDLE, DRIVE, DEAD} state_t;

    state_t        state, state_nx;
    logic [SW-1:0] slot, slot_nx;
    logic [1:0]    phase_nx;
    logic          end_slot;
    logic [3:0]    faz_nx;
    logic          done_nx;

    always_comb begin
        state_nx = state;
        slot_nx  = slot;
        phase_nx = phase;
        end_slot = 1'b0;
        unique case (state)
            IDLE: begin
                if (run || step) begin
                    state_nx = DRIVE;
                    slot_nx  = '0;
                    phase_nx = 2'd0;
                end
            end
            DRIVE: begin
                if (slot == DRV_LAST) begin
                    if (GAP > 0) begin
                        state_nx = DEAD;
                        slot_nx  = '0;
                    end else begin
                        end_slot = 1'b1;
                    end
                end else begin
                    slot_nx = slot + SW'(1);
                end
            end
            DEAD: begin
                if (slot == GAP_LAST) end_slot = 1'b1;
                else                  slot_nx  = slot + SW'(1);
            end
            default: state_nx = IDLE;
        endcase

        // Slot boundary: advance phase, or close the cycle and let run decide
        if (end_slot) begin
            slot_nx = '0;
            if (phase != 2'd3) begin
                phase_nx = phase + 2'd1;
                state_nx = DRIVE;
            end else if (run) begin
                phase_nx = 2'd0;
                state_nx = DRIVE;
            end else begin
                state_nx = IDLE;
            end
        end
    end

    // Output decode is taken from next-state so every output is a plain register
    always_comb begin
        faz_nx = 4'hF;
        for (int i = 0; i < 4; i++)
            faz_nx[i] = !(state_nx == DRIVE && phase_nx == 2'(i));
        done_nx = (phase_nx == 2'd3) &&
                  ((state_nx == DEAD && slot_nx == GAP_LAST) ||
                   (GAP == 0 && state_nx == DRIVE && slot_nx == DRV_LAST));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            slot        <= '0;
            phase       <= 2'd0;
            busy        <= 1'b0;
            cycle_done  <= 1'b0;
            cycle_count <= '0;
            FAZ1DR      <= 1'b1;
            FAZ2DR      <= 1'b1;
            FAZ3DR      <= 1'b1;
            FAZ4DR      <= 1'b1;
            FAZ2DR_n    <= 1'b0;
        end else begin
            state      <= state_nx;
            slot       <= slot_nx;
            phase      <= phase_nx;
            busy       <= (state_nx != IDLE);
            cycle_done <= done_nx;
            if (cycle_done) cycle_count <= cycle_count + CNT_W'(1);
            FAZ1DR     <= faz_nx[0];
            FAZ2DR     <= faz_nx[1];
            FAZ3DR     <= faz_nx[2];
            FAZ4DR     <= faz_nx[3];
            FAZ2DR_n   <= ~faz_nx[1];
        end
    end

endmodule
